// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared widths, Q1.15 constants and FSM encoding for the softmax normalizer
//
// Purpose : common definitions imported by the interface, the divider and the top.
// Ports   : none (package).
package softmax_pkg;

  localparam int EXP_W     = 16;   // Q1.15 exp / probability word
  localparam int SUM_W     = 24;   // Q9.15 row sum
  localparam int RECIP_W   = 31;   // floor(2^30 / sum)
  localparam int VEC_N     = 64;   // elements per row
  localparam int FRAC_BITS = 15;
  localparam int VEC_BITS  = EXP_W * VEC_N;

  localparam logic [EXP_W-1:0] Q15_ONE = 16'h8000;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_DIV  = 2'd1;
  localparam state_t ST_MUL  = 2'd2;

endpackage

// File: rtl/softmax_normalizer_if.sv
// rtl/softmax_normalizer_if.sv - row-in / probabilities-out bundle of the softmax normalizer
//
// Purpose : groups the reduction-stage inputs and the probability outputs.
// Signals : sum_in, sum_valid, exp_values_in (producer -> normalizer);
//           prob_out, prob_valid, busy, div_zero, overrun (normalizer -> consumer).
// Modports: master = reduction-stage side, slave = normalizer side.
interface softmax_normalizer_if;
  import softmax_pkg::*;

  logic [SUM_W-1:0]    sum_in;
  logic                sum_valid;
  logic [VEC_BITS-1:0] exp_values_in;
  logic [VEC_BITS-1:0] prob_out;
  logic                prob_valid;
  logic                busy;
  logic                div_zero;
  logic                overrun;

  modport master (
    output sum_in, sum_valid, exp_values_in,
    input  prob_out, prob_valid, busy, div_zero, overrun
  );

  modport slave (
    input  sum_in, sum_valid, exp_values_in,
    output prob_out, prob_valid, busy, div_zero, overrun
  );

endinterface

// File: rtl/recip_divider.sv
// rtl/recip_divider.sv - serial restoring divider producing floor(2^30 / divisor)
//
// Purpose : one quotient bit per cycle, MSB first, 31 cycles after start.
// Ports   : clk, rst_n (async active-low); start (load, divisor sampled on
//           the following cycles); divisor (must stay stable while running);
//           done (high in the cycle whose closing edge writes the last
//           quotient bit); quotient (complete from the cycle after done).
module recip_divider
  import softmax_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SUM_W-1:0]   divisor,
  output logic               done,
  output logic [RECIP_W-1:0] quotient
);

  logic             active;
  logic [4:0]       bit_idx;
  logic [SUM_W-1:0] rem;
  logic [SUM_W:0]   rem_sh;
  logic             fits;

  // Dividend is exactly 2^30: its only set bit enters on the first step.
  always_comb begin
    rem_sh = {rem, (bit_idx == 5'(RECIP_W - 1))};
    fits   = (rem_sh >= {1'b0, divisor});
  end

  assign done = active && (bit_idx == 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      bit_idx  <= '0;
      rem      <= '0;
      quotient <= '0;
    end else if (start) begin
      active   <= 1'b1;
      bit_idx  <= 5'(RECIP_W - 1);
      rem      <= '0;
      quotient <= '0;
    end else if (active) begin
      // When the subtract does not fit, rem_sh < divisor so its MSB is 0.
      rem      <= fits ? SUM_W'(rem_sh - {1'b0, divisor}) : rem_sh[SUM_W-1:0];
      quotient <= {quotient[RECIP_W-2:0], fits};
      if (bit_idx == 5'd0) active  <= 1'b0;
      else                 bit_idx <= bit_idx - 5'd1;
    end
  end

endmodule

// File: rtl/softmax_normalizer.sv
// rtl/softmax_normalizer.sv - scales 64 exp values by one reciprocal of their row sum
//
// Purpose : IDLE latches a row; DIV runs the 31-cycle reciprocal; MUL writes
//           LANES saturated Q1.15 probabilities per cycle into prob_out.
// Ports   : clk, rst_n (async active-low); bus (softmax_normalizer_if.slave):
//           sum_in/sum_valid/exp_values_in in, prob_out/prob_valid/busy/
//           div_zero/overrun out.
module softmax_normalizer
  import softmax_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  softmax_normalizer_if.slave  bus
);

  localparam int         GROUPS   = VEC_N / LANES;
  localparam logic [5:0] LAST_GRP = 6'(GROUPS - 1);

  state_t             state;
  logic [5:0]         grp;
  logic [SUM_W-1:0]   sum_q;
  logic [EXP_W-1:0]   exp_q  [VEC_N];
  logic [EXP_W-1:0]   prob_q [VEC_N];
  logic               zero_pend;
  logic               prob_valid_q;
  logic               div_zero_q;
  logic               overrun_q;
  logic               div_start;
  logic               div_done;
  logic [RECIP_W-1:0] recip;

  assign div_start = bus.sum_valid && (state == ST_IDLE) && (bus.sum_in != '0);

  recip_divider u_recip_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .divisor  (sum_q),
    .done     (div_done),
    .quotient (recip)
  );

  // (exp * recip) >> 15 on a 47-bit product; anything above 0xFFFF saturates.
  function automatic logic [EXP_W-1:0] scale_sat(input logic [EXP_W-1:0] e,
                                                  input logic [RECIP_W-1:0] r);
    logic [EXP_W+RECIP_W-1:0] prod;
    logic [31:0]              shifted;
    prod    = (EXP_W+RECIP_W)'(e) * (EXP_W+RECIP_W)'(r);
    shifted = 32'(prod >> FRAC_BITS);
    return (shifted > 32'h0000_FFFF) ? 16'hFFFF : shifted[EXP_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      grp          <= '0;
      sum_q        <= '0;
      zero_pend    <= 1'b0;
      prob_valid_q <= 1'b0;
      div_zero_q   <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < VEC_N; i++) begin
        exp_q[i]  <= '0;
        prob_q[i] <= '0;
      end
    end else begin
      prob_valid_q <= 1'b0;
      div_zero_q   <= 1'b0;
      zero_pend    <= 1'b0;
      overrun_q    <= bus.sum_valid && (state != ST_IDLE);

      // Zero-sum row completes one edge after it was sampled.
      if (zero_pend) begin
        for (int i = 0; i < VEC_N; i++) prob_q[i] <= '0;
        prob_valid_q <= 1'b1;
        div_zero_q   <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (bus.sum_valid) begin
            sum_q <= bus.sum_in;
            for (int i = 0; i < VEC_N; i++)
              exp_q[i] <= bus.exp_values_in[i*EXP_W +: EXP_W];
            if (bus.sum_in != '0) state     <= ST_DIV;
            else                  zero_pend <= 1'b1;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            state <= ST_MUL;
            grp   <= '0;
          end
        end
        ST_MUL: begin
          for (int j = 0; j < LANES; j++)
            prob_q[6'(int'(grp) * LANES + j)] <=
              scale_sat(exp_q[6'(int'(grp) * LANES + j)], recip);
          if (grp == LAST_GRP) begin
            state        <= ST_IDLE;
            prob_valid_q <= 1'b1;
          end else begin
            grp <= grp + 6'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < VEC_N; g++) begin : g_pack
    assign bus.prob_out[g*EXP_W +: EXP_W] = prob_q[g];
  end

  assign bus.prob_valid = prob_valid_q;
  assign bus.div_zero   = div_zero_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_softmax_normalizer.sv
// tb/tb_softmax_normalizer.sv - self-checking bench for softmax_normalizer at LANES = 1, 8, 64
module tb_softmax_normalizer;
  import softmax_pkg::*;

  localparam int NDUT = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [SUM_W-1:0]    sum_in = '0;
  logic                sum_valid = 1'b0;
  logic [VEC_BITS-1:0] exp_in = '0;

  always #5 clk = ~clk;

  softmax_normalizer_if if_l1 ();
  softmax_normalizer_if if_l8 ();
  softmax_normalizer_if if_l64 ();

  assign if_l1.sum_in  = sum_in;  assign if_l1.sum_valid  = sum_valid;  assign if_l1.exp_values_in  = exp_in;
  assign if_l8.sum_in  = sum_in;  assign if_l8.sum_valid  = sum_valid;  assign if_l8.exp_values_in  = exp_in;
  assign if_l64.sum_in = sum_in;  assign if_l64.sum_valid = sum_valid;  assign if_l64.exp_values_in = exp_in;

  softmax_normalizer #(.LANES(1))  dut_l1  (.clk(clk), .rst_n(rst_n), .bus(if_l1));
  softmax_normalizer #(.LANES(8))  dut_l8  (.clk(clk), .rst_n(rst_n), .bus(if_l8));
  softmax_normalizer #(.LANES(64)) dut_l64 (.clk(clk), .rst_n(rst_n), .bus(if_l64));

  logic [VEC_BITS-1:0] po [NDUT];
  logic pv [NDUT], bz [NDUT], dz [NDUT], ov [NDUT];
  assign po[0] = if_l1.prob_out;  assign pv[0] = if_l1.prob_valid;  assign bz[0] = if_l1.busy;  assign dz[0] = if_l1.div_zero;  assign ov[0] = if_l1.overrun;
  assign po[1] = if_l8.prob_out;  assign pv[1] = if_l8.prob_valid;  assign bz[1] = if_l8.busy;  assign dz[1] = if_l8.div_zero;  assign ov[1] = if_l8.overrun;
  assign po[2] = if_l64.prob_out; assign pv[2] = if_l64.prob_valid; assign bz[2] = if_l64.busy; assign dz[2] = if_l64.div_zero; assign ov[2] = if_l64.overrun;

  // ---------------- reference model state ----------------
  typedef struct {
    int                  due;
    logic [VEC_BITS-1:0] prob;
    logic                dz;
  } exp_t;

  exp_t eq [NDUT][$];
  int   busy_lo [NDUT];
  int   busy_hi [NDUT];
  int   free_edge [NDUT];
  int   ovr_cyc [NDUT];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lanes_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 8 : 64;
  endfunction

  function automatic int lat_of(input int k);
    return 31 + VEC_N / lanes_of(k);
  endfunction

  // Probabilities straight from the arithmetic definition.
  function automatic logic [VEC_BITS-1:0] model(input logic [SUM_W-1:0] s,
                                                input logic [VEC_BITS-1:0] e);
    logic [VEC_BITS-1:0] res;
    longint unsigned     r, ev, p;
    res = '0;
    r = (64'd1 << 30) / longint'(s);
    for (int i = 0; i < VEC_N; i++) begin
      ev = longint'(e[i*EXP_W +: EXP_W]);
      p  = (ev * r) >> 15;
      res[i*EXP_W +: EXP_W] = (p > 64'hFFFF) ? 16'hFFFF : p[15:0];
    end
    return res;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      eq[k].delete();
      busy_lo[k]   = -1;
      busy_hi[k]   = -1;
      free_edge[k] = 0;
      ovr_cyc[k]   = -1;
    end
  endtask

  task automatic chk(input string name, input logic [VEC_BITS-1:0] act,
                     input logic [VEC_BITS-1:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      for (int w = 0; w < VEC_N; w++) begin
        if (act[w*EXP_W +: EXP_W] !== exp_v[w*EXP_W +: EXP_W]) begin
          $display("FAIL %s word %0d: got %h expected %h (cycle %0d)", name, w,
                   act[w*EXP_W +: EXP_W], exp_v[w*EXP_W +: EXP_W], cyc);
          break;
        end
      end
    end
  endtask

  function automatic string nm(input string base, input int k);
    return $sformatf("%s[L%0d]", base, lanes_of(k));
  endfunction

  // ---------------- per-cycle compare ----------------
  logic pv_e;
  exp_t head;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NDUT; k++) begin
        pv_e = (eq[k].size() > 0) && (eq[k][0].due == cyc);
        chk(nm("prob_valid", k), VEC_BITS'(pv[k]), VEC_BITS'(pv_e));
        chk(nm("busy", k), VEC_BITS'(bz[k]),
            VEC_BITS'((cyc >= busy_lo[k]) && (cyc <= busy_hi[k])));
        chk(nm("overrun", k), VEC_BITS'(ov[k]), VEC_BITS'(cyc == ovr_cyc[k]));
        if (pv_e) begin
          head = eq[k].pop_front();
          chk(nm("prob_out", k), po[k], head.prob);
          chk(nm("div_zero", k), VEC_BITS'(dz[k]), VEC_BITS'(head.dz));
        end else begin
          chk(nm("div_zero", k), VEC_BITS'(dz[k]), '0);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a posedge; the row is sampled on the next edge (E0).
  task automatic apply_row(input logic [SUM_W-1:0] s, input logic [VEC_BITS-1:0] e);
    int   e0;
    exp_t x;
    e0 = cyc + 1;
    for (int k = 0; k < NDUT; k++) begin
      if (e0 >= free_edge[k]) begin
        x.dz = (s == '0);
        if (s == '0) begin
          x.due        = e0 + 1;
          x.prob       = '0;
          free_edge[k] = e0 + 1;
        end else begin
          x.due        = e0 + lat_of(k);
          x.prob       = model(s, e);
          busy_lo[k]   = e0;
          busy_hi[k]   = e0 + lat_of(k) - 1;
          free_edge[k] = e0 + lat_of(k) + 1;
        end
        eq[k].push_back(x);
      end else begin
        ovr_cyc[k] = e0;
      end
    end
    sum_in    = s;
    exp_in    = e;
    sum_valid = 1'b1;
    @(posedge clk); #1;
    sum_valid = 1'b0;
  endtask

  function automatic bit all_idle();
    for (int k = 0; k < NDUT; k++)
      if (eq[k].size() != 0 || free_edge[k] > cyc + 1 || busy_hi[k] >= cyc) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 200 && !all_idle()) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", VEC_BITS'(all_idle()), VEC_BITS'(1));
  endtask

  // Counts cycles from E0 (+1ns) until the LANES=8 instance pulses prob_valid.
  task automatic wait_l8(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!pv[1] && lat < 100) begin
      if (bz[1]) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < NDUT; k++) begin
      chk(nm({tag, "_prob_out"}, k), po[k], '0);
      chk(nm({tag, "_flags"}, k), VEC_BITS'({pv[k], bz[k], dz[k], ov[k]}), '0);
    end
  endtask

  function automatic logic [VEC_BITS-1:0] rand_vec();
    logic [VEC_BITS-1:0] v;
    for (int i = 0; i < VEC_N; i++) v[i*EXP_W +: EXP_W] = 16'($urandom);
    return v;
  endfunction

  // ---------------- directed sequence ----------------
  logic [VEC_BITS-1:0] v;
  logic [VEC_BITS-1:0] lit;
  logic [SUM_W-1:0]    s;
  int                  lat, bcnt, acc;

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Uniform row: every word 0x0200, 39-cycle latency, 39 busy cycles.
    for (int i = 0; i < VEC_N; i++) v[i*EXP_W +: EXP_W] = 16'h0200;
    apply_row(24'h008000, v);
    wait_l8(lat, bcnt);
    chk("uniform_latency", VEC_BITS'(lat), VEC_BITS'(39));
    chk("uniform_busy_cycles", VEC_BITS'(bcnt), VEC_BITS'(39));
    chk("uniform_busy_after", VEC_BITS'(bz[1]), '0);
    lit = {64{16'h0200}};
    chk("uniform_words", po[1], lit);
    wait_idle();

    // One-hot row.
    v = '0;
    v[5*EXP_W +: EXP_W] = Q15_ONE;
    apply_row(24'h008000, v);
    wait_idle();
    lit = '0;
    lit[5*EXP_W +: EXP_W] = 16'h8000;
    for (int k = 0; k < NDUT; k++) chk(nm("onehot_words", k), po[k], lit);

    // Zero sum: one-cycle completion with div_zero, busy never rises.
    apply_row(24'h000000, rand_vec());
    chk("zero_busy_e0", VEC_BITS'(bz[1]), '0);
    @(posedge clk); #1;
    chk("zero_pv", VEC_BITS'({pv[1], dz[1], bz[1]}), VEC_BITS'(3'b110));
    chk("zero_prob_out", po[1], '0);
    wait_idle();

    // Overrun: second row at cycle 10 is dropped, first result intact.
    apply_row(24'h01_2345, rand_vec());
    repeat (9) @(posedge clk);
    #1;
    apply_row(24'h00_4321, rand_vec());
    for (int k = 0; k < NDUT; k++) chk(nm("overrun_pulse", k), VEC_BITS'(ov[k]), VEC_BITS'(1));
    @(posedge clk); #1;
    chk("overrun_single", VEC_BITS'(ov[1]), '0);
    wait_idle();

    // Reset in the middle of MUL.
    apply_row(24'h00_9000, rand_vec());
    repeat (34) @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    v = rand_vec();
    apply_row(24'h00_A000, v);
    wait_l8(lat, bcnt);
    chk("postreset_latency", VEC_BITS'(lat), VEC_BITS'(39));
    wait_idle();

    // Saturation: exp 0xFFFF over a sum of 0x100.
    v = '0;
    v[EXP_W-1:0] = 16'hFFFF;
    apply_row(24'h000100, v);
    wait_idle();
    lit = '0;
    lit[EXP_W-1:0] = 16'hFFFF;
    for (int k = 0; k < NDUT; k++) chk(nm("saturate_words", k), po[k], lit);

    // Random rows, 40 cycles apart: LANES=8 takes each one on the cycle its
    // previous prob_valid is high; LANES=1 sees overruns in between.
    for (int r = 0; r < 1000; r++) begin
      v = rand_vec();
      case ($urandom_range(0, 3))
        0: s = 24'($urandom_range(1, 24'hFF_FFFF));
        1: s = 24'($urandom_range(1, 24'h00_00FF));
        2: s = 24'($urandom_range(24'h00_8000, 24'h20_0000));
        default: begin
          acc = 0;
          for (int i = 0; i < VEC_N; i++) acc += int'(v[i*EXP_W +: EXP_W]);
          s = (acc == 0) ? 24'd1 : 24'(acc);
        end
      endcase
      apply_row(s, v);
      repeat (39) @(posedge clk);
      #1;
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
